// File: rtl/bus_mux_n.sv
// Address-decoding bus multiplexer: one master, NSLAVES windowed slaves.
// Handles acknowledge, timeout and bus-error bookkeeping for each transfer.
module bus_mux_n #(
  parameter int                    NSLAVES = 6,
  parameter int                    SADDR_W = 8,
  parameter logic [NSLAVES*24-1:0] BASES   = '0,
  parameter logic [NSLAVES*24-1:0] MASKS   = '0,
  parameter int                    TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  as,
  input  logic [23:0]           master_addr,
  input  logic [15:0]           master_write,
  output logic [15:0]           master_read,
  input  logic                  master_uds,
  input  logic                  master_lds,
  input  logic                  master_rw,
  output logic                  master_ack,
  output logic                  master_berr,
  output logic [NSLAVES-1:0]    slave_sel,
  output logic [SADDR_W-1:0]    slave_addr,
  output logic [15:0]           slave_write,
  output logic [NSLAVES-1:0]    slave_uds,
  output logic [NSLAVES-1:0]    slave_lds,
  output logic                  slave_rw,
  input  logic [NSLAVES*16-1:0] slave_read,
  input  logic [NSLAVES-1:0]    slave_ack,
  output logic [7:0]            err_count,
  output logic [23:0]           err_addr
);

  localparam int IDX_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, ERR} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [23:0]        r_addr;
  logic [15:0]        r_wdata;
  logic               r_rw;
  logic               r_uds;
  logic               r_lds;
  logic [IDX_W-1:0]   r_idx;
  logic [TMO_W-1:0]   r_tmo;
  logic [15:0]        r_read;
  logic [7:0]         r_err_count;
  logic [23:0]        r_err_addr;

  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic               w_start;
  logic               w_ack;
  logic               w_tmo;
  logic [NSLAVES-1:0] w_onehot;

  // Scan from the top down so the lowest matching index is the one left standing.
  // NOTE: every signal written in always_comb gets a default first; otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((master_addr & MASKS[24*i +: 24]) == (BASES[24*i +: 24] & MASKS[24*i +: 24])) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  assign w_start  = as & (master_uds | master_lds);
  assign w_ack    = slave_ack[r_idx];
  assign w_tmo    = (TIMEOUT > 0) && (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_onehot = NSLAVES'(1) << r_idx;

  // Abort beats ack, and ack beats timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_start) w_next = w_hit ? ACTIVE : ERR;
      ACTIVE: begin
        if (!as)        w_next = IDLE;
        else if (w_ack) w_next = DONE;
        else if (w_tmo) w_next = ERR;
      end
      DONE, ERR: if (!as) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rw        <= 1'b1;
      r_uds       <= 1'b0;
      r_lds       <= 1'b0;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_read      <= '0;
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_start) begin
        r_addr  <= master_addr;
        r_wdata <= master_write;
        r_rw    <= master_rw;
        r_uds   <= master_uds;
        r_lds   <= master_lds;
        r_idx   <= w_idx;
        r_tmo   <= '0;
      end else if (r_state == ACTIVE) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (r_state == ACTIVE && as && w_ack && r_rw)
        r_read <= slave_read[16*r_idx +: 16];
      // From IDLE the address is being latched this same edge, so take it live.
      if (w_next == ERR && r_state != ERR) begin
        r_err_addr <= (r_state == IDLE) ? master_addr : r_addr;
        if (r_err_count != 8'hFF)
          r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign slave_sel   = (r_state == ACTIVE)          ? w_onehot : '0;
  assign slave_uds   = (r_state == ACTIVE && r_uds) ? w_onehot : '0;
  assign slave_lds   = (r_state == ACTIVE && r_lds) ? w_onehot : '0;
  assign slave_addr  = r_addr[SADDR_W-1:0];
  assign slave_write = r_wdata;
  assign slave_rw    = r_rw;
  assign master_read = r_read;
  assign master_ack  = (r_state == DONE);
  assign master_berr = (r_state == ERR);
  assign err_count   = r_err_count;
  assign err_addr    = r_err_addr;

endmodule
